// File: rtl/seg7_pkg.sv
// Shared types and glyph table for the multiplexed 7-segment display driver.
package seg7_pkg;

  // Segment order is {a,b,c,d,e,f,g}, a in the MSB, active-high.
  localparam logic [6:0] GLYPH_0     = 7'b1111110;
  localparam logic [6:0] GLYPH_1     = 7'b0110000;
  localparam logic [6:0] GLYPH_2     = 7'b1101101;
  localparam logic [6:0] GLYPH_3     = 7'b1111001;
  localparam logic [6:0] GLYPH_4     = 7'b0110011;
  localparam logic [6:0] GLYPH_5     = 7'b1011011;
  localparam logic [6:0] GLYPH_6     = 7'b1011111;
  localparam logic [6:0] GLYPH_7     = 7'b1110000;
  localparam logic [6:0] GLYPH_8     = 7'b1111111;
  localparam logic [6:0] GLYPH_9     = 7'b1111011;
  localparam logic [6:0] GLYPH_A     = 7'b1110111;
  localparam logic [6:0] GLYPH_B     = 7'b0011111;
  localparam logic [6:0] GLYPH_C     = 7'b1001110;
  localparam logic [6:0] GLYPH_D     = 7'b0111101;
  localparam logic [6:0] GLYPH_E     = 7'b1001111;
  localparam logic [6:0] GLYPH_F     = 7'b1000111;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  // One-entry update buffer occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

  // Code to glyph; codes 10-15 render as letters only when hex_en is set.
  function automatic logic [6:0] seg7_glyph(input logic [3:0] code, input logic hex_en);
    logic [6:0] g;
    case (code)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = hex_en ? GLYPH_A : GLYPH_BLANK;
      4'hB: g = hex_en ? GLYPH_B : GLYPH_BLANK;
      4'hC: g = hex_en ? GLYPH_C : GLYPH_BLANK;
      4'hD: g = hex_en ? GLYPH_D : GLYPH_BLANK;
      4'hE: g = hex_en ? GLYPH_E : GLYPH_BLANK;
      default: g = hex_en ? GLYPH_F : GLYPH_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit decoder: 4-bit code to active-high segment pattern.
module seg7_decode
  import seg7_pkg::*;
#(
  parameter int HEX_EN = 0
) (
  input  logic [3:0] code,
  output logic [6:0] seg
);

  localparam logic HEX = (HEX_EN != 0);

  // Pure table lookup; polarity is handled by the caller.
  always_comb begin
    seg = seg7_glyph(code, HEX);
  end

endmodule

// File: rtl/seg7_mux_display.sv
// Time-multiplexed N-digit 7-segment driver with frame-aligned updates,
// anti-ghosting blanking and optional leading-zero suppression.
module seg7_mux_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DIV            = 1000,
  parameter int BLANK          = 2,
  parameter int HEX_EN         = 0,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lzs_en,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLNK = CW'(BLANK);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  // XOR masks that turn active-high values into pin levels; also the idle level.
  localparam logic                  SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic                  AN_INV  = (AN_ACTIVE_LOW != 0);
  localparam logic [6:0]            SEG_OFF = {7{SEG_INV}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_INV}};

  // Scan position
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          slot_end, boundary;

  // Update buffering
  buf_state_e                state_q, state_d;
  logic [4*NUM_DIGITS-1:0]   pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic                      pend_lzs_q, pend_lzs_d;
  logic [4*NUM_DIGITS-1:0]   shd_dig_q, shd_dig_d;
  logic [NUM_DIGITS-1:0]     shd_dp_q, shd_dp_d;
  logic                      shd_lzs_q, shd_lzs_d;

  // Digit selection and decode
  logic [3:0]            shd_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] supp;
  logic                  zero_run;
  logic [3:0]            cur_code;
  logic                  cur_dp, cur_supp;
  logic [6:0]            glyph;
  logic [NUM_DIGITS-1:0] an_raw;
  logic [6:0]            seg_raw;
  logic                  dp_raw;

  // Registered pins
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  fd_q, fd_d;

  assign slot_end = (cnt_q == CNT_LAST);
  assign boundary = slot_end && (idx_q == IDX_LAST);

  // Prescaler and digit index; idx wraps explicitly so any NUM_DIGITS works.
  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  // Pending buffer takes one update; it moves to the shadow only on a frame
  // boundary so a frame is always drawn from a single consistent snapshot.
  always_comb begin
    state_d    = state_q;
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    pend_lzs_d = pend_lzs_q;
    shd_dig_d  = shd_dig_q;
    shd_dp_d   = shd_dp_q;
    shd_lzs_d  = shd_lzs_q;
    case (state_q)
      EMPTY: begin
        if (upd_valid) begin
          pend_dig_d = digits_in;
          pend_dp_d  = dp_in;
          pend_lzs_d = lzs_en;
          state_d    = FULL;
        end
      end
      default: begin
        if (boundary) begin
          shd_dig_d = pend_dig_q;
          shd_dp_d  = pend_dp_q;
          shd_lzs_d = pend_lzs_q;
          state_d   = EMPTY;
        end
      end
    endcase
  end

  assign upd_ready = (state_q == EMPTY);

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_unpack
    assign shd_arr[k] = shd_dig_q[4*k +: 4];
  end

  // Suppression mask: a digit is blanked while it and every digit above it are
  // zero. Digit 0 stays visible so a zero value still shows "0".
  always_comb begin
    supp     = '0;
    zero_run = shd_lzs_q;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (shd_arr[k] == 4'd0);
      supp[k]  = zero_run;
    end
  end

  assign cur_code = shd_arr[idx_q];
  assign cur_dp   = shd_dp_q[idx_q];
  assign cur_supp = supp[idx_q];

  seg7_decode #(.HEX_EN(HEX_EN)) u_decode (
    .code (cur_code),
    .seg  (glyph)
  );

  // Slot outputs: anode held off for the first BLANK cycles of each slot so
  // segment lines settle before the next digit lights.
  always_comb begin
    an_raw = '0;
    if ((cnt_q >= CNT_BLNK) && !cur_supp) an_raw[idx_q] = 1'b1;
    seg_raw = cur_supp ? GLYPH_BLANK : glyph;
    dp_raw  = cur_dp & ~cur_supp;
    an_d    = an_raw ^ AN_OFF;
    seg_d   = seg_raw ^ SEG_OFF;
    dp_d    = dp_raw ^ SEG_INV;
    fd_d    = boundary;
  end

  // Scan state and buffers; reset discards any pending update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      state_q    <= EMPTY;
      pend_dig_q <= '0;
      pend_dp_q  <= '0;
      pend_lzs_q <= 1'b0;
      shd_dig_q  <= '0;
      shd_dp_q   <= '0;
      shd_lzs_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      state_q    <= state_d;
      pend_dig_q <= pend_dig_d;
      pend_dp_q  <= pend_dp_d;
      pend_lzs_q <= pend_lzs_d;
      shd_dig_q  <= shd_dig_d;
      shd_dp_q   <= shd_dp_d;
      shd_lzs_q  <= shd_lzs_d;
    end
  end

  // Output pin registers; reset drives every pin to its inactive level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      dp_q  <= SEG_INV;
      fd_q  <= 1'b0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      fd_q  <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule
